switch_debouncer: RTL
=====================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, the stable-input window in clock cycles (10 ms at 25 MHz), legal range 1..2^24-1.
REQ-002 The block SHALL have port i_Clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port i_Switch, input, 4 bits, the raw asynchronous board switches, active-high when pressed.
REQ-005 The block SHALL have port o_Switch, output, 4 bits, the debounced switch levels.
REQ-006 The block SHALL have port o_Press, output, 4 bits, a one-cycle pulse per channel on each debounced 0->1 transition.
REQ-007 The block SHALL have port o_Release, output, 4 bits, a one-cycle pulse per channel on each debounced 1->0 transition.
REQ-008 The block SHALL have port o_Toggle, output, 4 bits, a per-channel level that inverts on every o_Press pulse.

Function
REQ-009 Each channel SHALL pass i_Switch[i] through a 2-flop synchronizer before any other logic uses it.
REQ-010 Each channel SHALL have a counter of width $clog2(DEBOUNCE_CYCLES+1) that clears in any cycle where the synchronized input equals o_Switch[i].
REQ-011 While the synchronized input differs from o_Switch[i], the counter SHALL increment each cycle; on the cycle it would reach DEBOUNCE_CYCLES, o_Switch[i] SHALL take the synchronized value and the counter SHALL clear.
REQ-012 Latency from a clean i_Switch edge to o_Switch change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-013 A glitch held for fewer than DEBOUNCE_CYCLES synchronized cycles SHALL leave o_Switch, o_Press, o_Release, and o_Toggle unchanged and reset the counter.
REQ-014 o_Press[i] and o_Release[i] SHALL be registered and asserted in the same cycle that o_Switch[i] changes, and deasserted in the next cycle.
REQ-015 o_Press[i] and o_Release[i] SHALL never be high together, and neither SHALL stay high for two consecutive cycles.
REQ-016 o_Toggle[i] SHALL invert in the same cycle as o_Press[i], and SHALL be unaffected by o_Release[i].
REQ-017 Channels SHALL be fully independent; simultaneous edges on several channels SHALL produce simultaneous, independent pulses.
REQ-018 With DEBOUNCE_CYCLES=1, the latency SHALL be 3 cycles and no counter overflow or wrap SHALL occur.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES, so no wrap-around is possible.

Reset
REQ-020 Asserting i_Rst_n low SHALL immediately clear the synchronizers, counters, o_Switch, o_Press, o_Release, and o_Toggle to 0.
REQ-021 Reset mid-count SHALL discard the partial count; after release, counting SHALL restart from 0.
REQ-022 If a switch is held high through reset release, exactly one o_Press pulse SHALL occur 2 + DEBOUNCE_CYCLES cycles after release.

Structure
REQ-023 The default DEBOUNCE_CYCLES value and the channel count (4) SHALL be defined as constants in a shared package, board_pkg.
REQ-024 A single sub-module, debounce_channel, SHALL contain the synchronizer, counter, level, pulses, and toggle for one channel, instantiated 4 times.
REQ-025 The block SHALL contain no combinational path from i_Switch to any output.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Scenario: i_Switch[0] steps 0->1 and is held -> o_Switch[0]=1 and o_Press[0]=1 for one cycle exactly 6 cycles after the edge, and o_Toggle[0]=1.
REQ-027 Scenario: i_Switch[1] takes a 3-cycle high glitch -> no output changes on any channel.
REQ-028 Scenario: i_Switch[2] is bounced 1,0,1,0,1 at 1-cycle spacing, then held high -> exactly one o_Press[2], 6 cycles after the final edge.
REQ-029 Scenario: i_Switch[3] does press, release, press -> o_Toggle[3] sequence 0->1->1->0, and one o_Release[3] pulse 6 cycles after the release edge.
REQ-030 Scenario: i_Switch=4'b1111 applied together -> o_Press=4'b1111 in the same cycle.
REQ-031 Scenario: i_Rst_n is pulsed low 3 cycles into a count -> all outputs read 0 at once, and o_Press fires 6 cycles after reset release.

Source files
------------

// File: rtl/board_pkg.sv
// Board-level constants shared by the switch debouncer and its channels.
package board_pkg;

  localparam int NUM_SWITCHES            = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  // The counter must be able to hold 0..cycles without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundle of the raw switch inputs and the debounced outputs of switch_debouncer.
interface switch_debouncer_if
  import board_pkg::*;
  ();

  logic [NUM_SWITCHES-1:0] sw;
  logic [NUM_SWITCHES-1:0] level;
  logic [NUM_SWITCHES-1:0] press;
  logic [NUM_SWITCHES-1:0] rel;
  logic [NUM_SWITCHES-1:0] toggle;

  modport master (output sw, input level, press, rel, toggle);
  modport slave  (input sw, output level, press, rel, toggle);

endinterface

// File: rtl/switch_debouncer_channel.sv
// One debounced switch: 2-flop synchronizer, stability counter, level, edge pulses, toggle.
module debounce_channel
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Toggle
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_Sync_p0;
  logic             r_Sync_p1;
  logic [CNT_W-1:0] r_Count;
  logic             r_Level;
  logic             r_Press;
  logic             r_Release;
  logic             r_Toggle;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Sync_p0 <= 1'b0;
      r_Sync_p1 <= 1'b0;
      r_Count   <= '0;
      r_Level   <= 1'b0;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      r_Toggle  <= 1'b0;
    end else begin
      // stage p0/p1: metastability guard on the raw pin
      r_Sync_p0 <= i_Switch;
      r_Sync_p1 <= r_Sync_p0;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      // commit on the cycle the count would reach DEBOUNCE_CYCLES, so it never exceeds it
      if (r_Sync_p1 == r_Level) begin
        r_Count <= '0;
      end else if (r_Count == CNT_LAST) begin
        r_Count   <= '0;
        r_Level   <= r_Sync_p1;
        r_Press   <= r_Sync_p1;
        r_Release <= ~r_Sync_p1;
        if (r_Sync_p1) r_Toggle <= ~r_Toggle;
      end else begin
        r_Count <= r_Count + CNT_W'(1);
      end
    end
  end

  assign o_Switch  = r_Level;
  assign o_Press   = r_Press;
  assign o_Release = r_Release;
  assign o_Toggle  = r_Toggle;

endmodule

// File: rtl/switch_debouncer.sv
// Four independent debounced board switches with press/release pulses and toggle levels.
module switch_debouncer
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Release,
  output logic [NUM_SWITCHES-1:0] o_Toggle
);

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .i_Clk     (i_Clk),
      .i_Rst_n   (i_Rst_n),
      .i_Switch  (i_Switch[g]),
      .o_Switch  (o_Switch[g]),
      .o_Press   (o_Press[g]),
      .o_Release (o_Release[g]),
      .o_Toggle  (o_Toggle[g])
    );
  end

endmodule
